// File: rtl/stack_ctrl_pkg.sv
// ============================================================
// stack_ctrl_pkg - shared opcodes, states and mux encodings for the stack sequencer
// Rev 1.0
// ============================================================
`default_nettype none

package stack_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam logic [2:0] c_OP_PUSH_ALU = 3'b000;
  localparam logic [2:0] c_OP_PUSH_MEM = 3'b001;
  localparam logic [2:0] c_OP_PUSH_RET = 3'b010;
  localparam logic [2:0] c_OP_PUSH_ARG = 3'b011;
  localparam logic [2:0] c_OP_DUP      = 3'b100;
  localparam logic [2:0] c_OP_POP      = 3'b101;
  localparam logic [2:0] c_OP_STORE    = 3'b110;
  localparam logic [2:0] c_OP_RESTORE  = 3'b111;

  localparam logic [2:0] c_SEL_ALU  = 3'b000;
  localparam logic [2:0] c_SEL_MEM  = 3'b001;
  localparam logic [2:0] c_SEL_RET  = 3'b010;
  localparam logic [2:0] c_SEL_ARG  = 3'b011;
  localparam logic [2:0] c_SEL_READ = 3'b100;

  localparam logic [3:0] c_S_IDLE      = 4'd0;
  localparam logic [3:0] c_S_RD_WAIT   = 4'd1;
  localparam logic [3:0] c_S_RD_LATCH  = 4'd2;
  localparam logic [3:0] c_S_MEM_WAIT  = 4'd3;
  localparam logic [3:0] c_S_MEM_LATCH = 4'd4;
  localparam logic [3:0] c_S_LATCH     = 4'd5;
  localparam logic [3:0] c_S_TOS_INC   = 4'd6;
  localparam logic [3:0] c_S_WRITE     = 4'd7;
  localparam logic [3:0] c_S_MEM_REG   = 4'd8;
  localparam logic [3:0] c_S_MEM_WR    = 4'd9;
  localparam logic [3:0] c_S_TOS_DEC   = 4'd10;
  localparam logic [3:0] c_S_TOS_LOAD  = 4'd11;
  localparam logic [3:0] c_S_ERR       = 4'd12;

  // Push-class ops (including DUP) grow the stack and can overflow.
  function automatic logic is_push_op(input logic [2:0] op);
    return op <= c_OP_DUP;
  endfunction

  // Ops that read the current top of stack and therefore need depth > 0.
  function automatic logic needs_data(input logic [2:0] op);
    return (op == c_OP_DUP) || (op == c_OP_POP) || (op == c_OP_STORE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_depth_tracker.sv
// ============================================================
// stack_depth_tracker - shadow depth counter with full/empty flags
// Rev 1.0
// ============================================================
`default_nettype none

module stack_depth_tracker #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_value,
  output logic [ADDR_WIDTH-1:0] depth,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH-1:0] c_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_depth;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth <= '0;
    end else if (load) begin
      r_depth <= load_value;
    end else if (inc) begin
      r_depth <= r_depth + c_ONE;
    end else if (dec) begin
      r_depth <= r_depth - c_ONE;
    end
  end

  assign depth = r_depth;
  assign full  = (r_depth == {ADDR_WIDTH{1'b1}});
  assign empty = (r_depth == '0);

endmodule

`default_nettype wire

// File: rtl/stack_op_sequencer.sv
// ============================================================
// stack_op_sequencer - Moore FSM sequencing the stack/TOS datapath, one op at a time
// Rev 1.0
// ============================================================
`default_nettype none

module stack_op_sequencer
  import stack_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int OPC_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [OPC_WIDTH-1:0]  op_code,
  input  logic [ADDR_WIDTH-1:0] restore_depth,
  output logic                  op_ready,
  output logic                  op_done,
  output logic                  op_err,
  output logic [ADDR_WIDTH-1:0] depth,
  output logic [2:0]            sel_mux_stack,
  output logic                  ctrl_reg_read_stack,
  output logic                  ctrl_reg_write_stack,
  output logic                  ctrl_reg_read_mem,
  output logic                  ctrl_reg_write_mem,
  output logic                  sel_mux_tos,
  output logic                  ctrl_reg_tos,
  output logic                  sel_tos_updater,
  output logic                  ctrl_stack,
  output logic                  ctrl_mem_ext
);

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_op;
  logic [2:0]            w_op_in;
  logic [ADDR_WIDTH-1:0] r_restore;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_reject;

  assign w_op_in  = 3'(op_code);
  assign w_accept = op_valid && (r_state == c_S_IDLE);
  assign w_reject = (is_push_op(w_op_in) && w_full) || (needs_data(w_op_in) && w_empty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= c_S_IDLE;
      r_op      <= '0;
      r_restore <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= w_op_in;
        r_restore <= restore_depth;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (op_valid) begin
          if (w_reject) begin
            w_next = c_S_ERR;
          end else begin
            case (w_op_in)
              c_OP_PUSH_MEM:                     w_next = c_S_MEM_WAIT;
              c_OP_DUP, c_OP_POP, c_OP_STORE:    w_next = c_S_RD_WAIT;
              c_OP_RESTORE:                      w_next = c_S_TOS_LOAD;
              default:                           w_next = c_S_LATCH;
            endcase
          end
        end
      end
      c_S_RD_WAIT:   w_next = c_S_RD_LATCH;
      c_S_RD_LATCH: begin
        case (r_op)
          c_OP_DUP: w_next = c_S_LATCH;
          c_OP_POP: w_next = c_S_TOS_DEC;
          default:  w_next = c_S_MEM_REG;
        endcase
      end
      c_S_MEM_WAIT:  w_next = c_S_MEM_LATCH;
      c_S_MEM_LATCH: w_next = c_S_LATCH;
      c_S_LATCH:     w_next = c_S_TOS_INC;
      c_S_TOS_INC:   w_next = c_S_WRITE;
      c_S_MEM_REG:   w_next = c_S_MEM_WR;
      c_S_MEM_WR:    w_next = c_S_TOS_DEC;
      default:       w_next = c_S_IDLE;
    endcase
  end

  // Pure decode of the state register (plus the op captured at acceptance).
  always_comb begin
    sel_mux_stack        = c_SEL_ALU;
    ctrl_reg_read_stack  = 1'b0;
    ctrl_reg_write_stack = 1'b0;
    ctrl_reg_read_mem    = 1'b0;
    ctrl_reg_write_mem   = 1'b0;
    sel_mux_tos          = 1'b0;
    ctrl_reg_tos         = 1'b0;
    sel_tos_updater      = 1'b0;
    ctrl_stack           = 1'b0;
    ctrl_mem_ext         = 1'b0;
    case (r_state)
      c_S_RD_LATCH:  ctrl_reg_read_stack = 1'b1;
      c_S_MEM_LATCH: ctrl_reg_read_mem   = 1'b1;
      c_S_LATCH: begin
        ctrl_reg_write_stack = 1'b1;
        case (r_op)
          c_OP_PUSH_MEM: sel_mux_stack = c_SEL_MEM;
          c_OP_DUP:      sel_mux_stack = c_SEL_READ;
          default:       sel_mux_stack = r_op;
        endcase
      end
      c_S_TOS_INC: begin
        ctrl_reg_tos    = 1'b1;
        sel_tos_updater = 1'b1;
      end
      c_S_WRITE:   ctrl_stack         = 1'b1;
      c_S_MEM_REG: ctrl_reg_write_mem = 1'b1;
      c_S_MEM_WR:  ctrl_mem_ext       = 1'b1;
      c_S_TOS_DEC: ctrl_reg_tos       = 1'b1;
      c_S_TOS_LOAD: begin
        ctrl_reg_tos = 1'b1;
        sel_mux_tos  = 1'b1;
      end
      default: ;
    endcase
  end

  assign op_ready = (r_state == c_S_IDLE);
  assign op_err   = (r_state == c_S_ERR);
  assign op_done  = (r_state == c_S_WRITE) || (r_state == c_S_TOS_DEC) ||
                    (r_state == c_S_TOS_LOAD) || (r_state == c_S_ERR);

  stack_depth_tracker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_depth (
    .clk        (clk),
    .reset      (reset),
    .inc        (r_state == c_S_TOS_INC),
    .dec        (r_state == c_S_TOS_DEC),
    .load       (r_state == c_S_TOS_LOAD),
    .load_value (r_restore),
    .depth      (depth),
    .full       (w_full),
    .empty      (w_empty)
  );

endmodule

`default_nettype wire
